// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - op, register-mode and FSM state encodings for the shift sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROTL = 2'b11
    } op_e;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_UP   = 2'b01;
    localparam logic [1:0] CTRL_DOWN = 2'b10;
    localparam logic [1:0] CTRL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic [1:0] op_to_ctrl(input logic [1:0] op);
        case (op)
            OP_LOAD: op_to_ctrl = CTRL_LOAD;
            OP_SHR:  op_to_ctrl = CTRL_DOWN;
            default: op_to_ctrl = CTRL_UP;
        endcase
    endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer driving a bidirectional PIPO shift register
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] q_fb,
    output logic [1:0]       ctrl,
    output logic [WIDTH-1:0] d,
    output logic             xl,
    output logic             xr,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_nxt;
    logic [CNT_W-1:0] rem_q, rem_nxt;
    logic [1:0]       ctrl_q, ctrl_nxt;
    logic [WIDTH-1:0] d_q, d_nxt;
    logic             xl_q, xl_nxt;
    logic             xr_q, xr_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             accept;
    logic             skip_run;
    logic             rotl_run;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic [1:0] op_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            op_q <= OP_LOAD;
        end else if (accept) begin
            op_q <= cmd_op;
        end
    end

    // A registered feedback bit would be one shift stale, so rotate taps q_fb live.
    assign rotl_run = (state_q == ST_RUN) && (op_q == OP_ROTL);
    assign xl       = rotl_run ? q_fb[WIDTH-1] : xl_q;
    assign skip_run = (cmd_op != OP_LOAD) && (cmd_count == '0);
`else
    logic unused_qfb;

    assign unused_qfb = ^q_fb;
    assign rotl_run   = 1'b0;
    assign xl         = xl_q;
    assign skip_run   = (cmd_op == OP_ROTL) ||
                        ((cmd_op != OP_LOAD) && (cmd_count == '0));
`endif

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = skip_run ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rem_q == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rem_nxt  = rem_q;
        ctrl_nxt = ctrl_q;
        d_nxt    = d_q;
        xl_nxt   = xl_q;
        xr_nxt   = xr_q;
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                ctrl_nxt = CTRL_HOLD;
                if (accept && !skip_run) begin
                    ctrl_nxt = op_to_ctrl(cmd_op);
                    rem_nxt  = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;
                    case (cmd_op)
                        OP_LOAD: d_nxt = cmd_data;
                        OP_SHL: begin
                            xl_nxt = cmd_fill;
                            xr_nxt = 1'b0;
                        end
                        OP_SHR: begin
                            xl_nxt = 1'b0;
                            xr_nxt = cmd_fill;
                        end
                        default: begin
                            xl_nxt = 1'b0;
                            xr_nxt = 1'b0;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (rem_q != '0) begin
                    rem_nxt = rem_q - CNT_W'(1);
                end
                if (rotl_run) begin
                    xl_nxt = q_fb[WIDTH-1];
                end
                if (state_nxt != ST_RUN) begin
                    ctrl_nxt = CTRL_HOLD;
                end
            end
            default: ctrl_nxt = CTRL_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rem_q  <= '0;
            ctrl_q <= CTRL_HOLD;
            d_q    <= '0;
            xl_q   <= 1'b0;
            xr_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_nxt;
            ctrl_q <= ctrl_nxt;
            d_q    <= d_nxt;
            xl_q   <= xl_nxt;
            xr_q   <= xr_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    assign ctrl = ctrl_q;
    assign d    = d_q;
    assign xr   = xr_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
